irq_scheduler: RTL
==================

// Module: irq_scheduler
// PURPOSE
//   Shares the two XDMA user-interrupt vectors among NUM_SRC user event sources.
//   - Latches rising edges per source into a pending register.
//   - Grants one unmasked pending source at a time, round-robin.
//   - Drives the granted vector's request level until acknowledged, then enforces a holdoff gap.
//   - Sits between the terminal datapath event logic and the PCIe core usr_irq_req/ack pins.
// PARAMETERS
//   NUM_SRC      4      number of user event sources (2..8)
//   NUM_VEC      2      interrupt vectors; source s maps to vector s % NUM_VEC
//   ACK_TIMEOUT  50000  cycles in ASSERT without ack before abandoning the request
//   HOLDOFF      16     cycles request stays low after ack/timeout before next grant (>=1)
// PORTS
//   i_clk             in   1        core user clock
//   i_rst             in   1        synchronous, active-high reset
//   i_src_irq         in   NUM_SRC  per-source event level; rising edge = new event
//   i_src_mask        in   NUM_SRC  1 = source masked (stays pending, never granted)
//   i_pending_clr     in   NUM_SRC  host write-1-to-clear of pending bits
//   o_src_pending     out  NUM_SRC  pending register
//   o_interrupt_req   out  NUM_VEC  level request to PCIe core, at most one bit high
//   i_interrupt_ack   in   NUM_VEC  1-cycle ack pulse from PCIe core
//   o_active_src      out  3        index of granted source (valid while o_busy)
//   o_busy            out  1        FSM not in IDLE
//   o_timeout         out  1        1-cycle pulse when ACK_TIMEOUT expires
// BEHAVIOUR
//   Reset: all regs/outputs 0; FSM=IDLE; rr pointer=0; edge-detect history=0.
//   Pending: per bit, set on edge (i_src_irq & ~prev) has priority over clears (host clr or ack clr) in the same cycle.
//   FSM states:
//   - IDLE: eligible = pending & ~mask. If nonzero, pick the first set bit searching upward from the rr pointer with wrap.
//     Register it in o_active_src; go ASSERT. Decision takes 1 cycle; req rises on the cycle after the edge is latched.
//   - ASSERT: o_interrupt_req[active % NUM_VEC] = 1, others 0; the cycle counter increments.
//     - On i_interrupt_ack[that vector]: clear pending[active]; rr pointer = (active+1) % NUM_SRC; req low next cycle; go HOLD.
//     - Acks on other vectors are ignored.
//     - Counter reaching ACK_TIMEOUT-1 without ack: pulse o_timeout; pending stays set; rr pointer advances; req low; go HOLD.
//     - Ack on the same cycle as timeout: treated as ack, no timeout pulse.
//   - HOLD: req all 0; count HOLDOFF cycles, then IDLE. Acks in HOLD are ignored.
//   Mask/clear during ASSERT: the request is not withdrawn; it completes normally.
//     A cleared pending bit stays cleared (ack clear is idempotent).
//   Counter: 16-bit, zeroed on every state entry.
//   Reset mid-ASSERT: req drops on the cycle after i_rst is sampled high.
// CONFIGURATION
//   IRQ_COALESCE_EN defined:
//     - an ack clears pending for ALL sources mapping to the acked vector (s % NUM_VEC == v),
//       except bits with a same-cycle edge;
//     - the rr pointer still advances past active.
//   IRQ_COALESCE_EN undefined: an ack clears only pending[active].
// TESTING
//   1. Reset, edge on src0 -> req[0]=1 two cycles after edge; ack[0] pulse -> req[0]=0 next cycle,
//      pending=0000, busy low after 16 HOLD cycles.
//   2. Edges src0..src3 same cycle -> grants in order 0,1,2,3 on req[0],req[1],req[0],req[1];
//      each waits for its ack plus HOLDOFF.
//   3. src1 pending, no ack -> o_timeout pulses at cycle 50000 of ASSERT; pending[1] still 1;
//      regranted after HOLD.
//   4. mask=0010 with src1,src2 pending -> src2 granted, src1 stays pending;
//      unmask -> src1 granted next.
//   5. New edge on src0 in the same cycle as ack of src0 -> pending[0] remains 1; src0 granted again.
//   6. IRQ_COALESCE_EN: src0 and src2 pending, src0 granted, ack[0] -> pending=0000,
//      no second request; undefined -> src2 granted after HOLD.

Source files
------------

// File: rtl/irq_scheduler.sv
// Round-robin scheduler sharing the XDMA user-interrupt vectors among event sources.
// Optional IRQ_COALESCE_EN: an ack clears every pending source mapped to the acked vector.
module irq_scheduler #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned NUM_VEC     = 2,
    parameter int unsigned ACK_TIMEOUT = 50000,
    parameter int unsigned HOLDOFF     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_SRC-1:0] i_src_irq,
    input  logic [NUM_SRC-1:0] i_src_mask,
    input  logic [NUM_SRC-1:0] i_pending_clr,
    output logic [NUM_SRC-1:0] o_src_pending,
    output logic [NUM_VEC-1:0] o_interrupt_req,
    input  logic [NUM_VEC-1:0] i_interrupt_ack,
    output logic [2:0]         o_active_src,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_nxt;
    logic [IDX_W-1:0]   active_nxt;
    logic [IDX_W-1:0]   after_active;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] ack_src_mask;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_VEC-1:0] req_nxt;
    logic [NUM_VEC-1:0] pick_req;
    logic               busy_nxt;
    logic               timeout_nxt;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               ack_hit;
    int                 active_vec;

    assign src_edge = i_src_irq & ~src_prev;
    assign eligible = o_src_pending & ~i_src_mask;

    // First eligible source at or above the rr pointer, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            for (int s = 0; s < int'(NUM_SRC); s++) begin
                if (!pick_found && eligible[s] &&
                    (s == ((int'(rr_ptr) + i) % int'(NUM_SRC)))) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(s);
                end
            end
        end
        for (int v = 0; v < int'(NUM_VEC); v++) begin
            pick_req[v] = ((int'(pick_idx) % int'(NUM_VEC)) == v);
        end
    end

    // Ack decode for the vector owned by the active source
    always_comb begin
        active_vec   = int'(o_active_src) % int'(NUM_VEC);
        after_active = IDX_W'((int'(o_active_src) + 1) % int'(NUM_SRC));
        ack_hit      = 1'b0;
        for (int v = 0; v < int'(NUM_VEC); v++) begin
            if (v == active_vec) begin
                ack_hit = i_interrupt_ack[v];
            end
        end
        for (int s = 0; s < int'(NUM_SRC); s++) begin
`ifdef IRQ_COALESCE_EN
            ack_src_mask[s] = ((s % int'(NUM_VEC)) == active_vec);
`else
            ack_src_mask[s] = (s == int'(o_active_src));
`endif
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rr_nxt      = rr_ptr;
        active_nxt  = o_active_src;
        req_nxt     = o_interrupt_req;
        timeout_nxt = 1'b0;
        ack_clr     = '0;

        case (state)
            ST_IDLE: begin
                req_nxt = '0;
                if (pick_found) begin
                    active_nxt = pick_idx;
                    req_nxt    = pick_req;
                    cnt_nxt    = '0;
                    state_nxt  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (ack_hit) begin
                    ack_clr   = ack_src_mask;
                    rr_nxt    = after_active;
                    req_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_HOLD;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_nxt = 1'b1;
                    rr_nxt      = after_active;
                    req_nxt     = '0;
                    cnt_nxt     = '0;
                    state_nxt   = ST_HOLD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                req_nxt = '0;
                if (cnt == CNT_W'(HOLDOFF - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                req_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        // A same-cycle edge wins over host and ack clears
        pending_nxt = (o_src_pending & ~(i_pending_clr | ack_clr)) | src_edge;
        busy_nxt    = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            rr_ptr          <= '0;
            src_prev        <= '0;
            o_src_pending   <= '0;
            o_interrupt_req <= '0;
            o_active_src    <= '0;
            o_busy          <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            rr_ptr          <= rr_nxt;
            src_prev        <= i_src_irq;
            o_src_pending   <= pending_nxt;
            o_interrupt_req <= req_nxt;
            o_active_src    <= active_nxt;
            o_busy          <= busy_nxt;
            o_timeout       <= timeout_nxt;
        end
    end

endmodule
